// File: rtl/arb_pkg.sv
// Shared constants and one-hot rotate helpers for the round-robin arbiter.
package arb_pkg;

  localparam DIR_LSB = "LSB";
  localparam DIR_MSB = "MSB";

  // The class is only a container that lets the rotate functions take a width parameter.
  virtual class oht_rot #(parameter int WIDTH = 2);
    static function logic [WIDTH-1:0] rotl_oht(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    static function logic [WIDTH-1:0] rotr_oht(input logic [WIDTH-1:0] x);
      return {x[0], x[WIDTH-1:1]};
    endfunction
  endclass

endpackage

// File: rtl/oht2bin_base.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module oht2bin_base #(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0,
  parameter     DIRECTION      = "LSB",
  localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] bin
);
  import arb_pkg::*;

  if (IMPLEMENTATION == 0) begin : g_or
    // OR of the indices of every set bit: exact for one-hot, zero for zero.
    always_comb begin
      // NOTE: assigning a default before any conditional write keeps always_comb latch-free.
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (oht[i]) bin = bin | WIDTH_LOG'(i);
      end
    end
  end else begin : g_prio
    // Priority variant: for a non-one-hot input the first bit in DIRECTION order wins.
    always_comb begin
      bin = '0;
      if (DIRECTION == DIR_LSB) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (oht[i]) bin = WIDTH_LOG'(i);
        end
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (oht[i]) bin = WIDTH_LOG'(i);
        end
      end
    end
  end

endmodule

// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with a registered one-hot grant, binary index and valid/ready hold.
module arb_rr_oht
  import arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter     DIRECTION  = "LSB",
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] gnt_bin
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "arb_rr_oht: WIDTH must be >= 2");
  end
  if (DIRECTION != DIR_LSB && DIRECTION != DIR_MSB) begin : g_bad_dir
    $fatal(1, "arb_rr_oht: DIRECTION must be \"LSB\" or \"MSB\"");
  end

  localparam bit IS_LSB = (DIRECTION == DIR_LSB);
  localparam logic [WIDTH-1:0] PTR_RST = IS_LSB ? WIDTH'(1) : {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH-1:0] ptr;
  logic [WIDTH-1:0] ptr_eff;
  logic [WIDTH-1:0] gnt_rot;
  logic [WIDTH-1:0] prio_mask;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] arb;
  logic             transfer;
  logic             ld;

  function automatic logic [WIDTH-1:0] lowest(input logic [WIDTH-1:0] x);
    return x & (~x + WIDTH'(1));
  endfunction

  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] first_set(input logic [WIDTH-1:0] x);
    return IS_LSB ? lowest(x) : reverse(lowest(reverse(x)));
  endfunction

  assign transfer = gnt_vld && gnt_rdy;
  assign ld       = !gnt_vld || gnt_rdy;
  assign gnt_rot  = IS_LSB ? oht_rot#(WIDTH)::rotl_oht(gnt_oht)
                           : oht_rot#(WIDTH)::rotr_oht(gnt_oht);
  // The just-served requester drops to lowest priority in the same cycle it completes.
  assign ptr_eff  = transfer ? gnt_rot : ptr;

  // Masked pass covers the pointer up to the wrap point; the unmasked pass handles the wrap.
  always_comb begin
    prio_mask = IS_LSB ? ~(ptr_eff - WIDTH'(1)) : (ptr_eff | (ptr_eff - WIDTH'(1)));
    masked    = req & prio_mask;
    arb       = (|masked) ? first_set(masked) : first_set(req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_vld <= 1'b0;
      gnt_oht <= '0;
      ptr     <= PTR_RST;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (ld) begin
        gnt_vld <= |req;
        gnt_oht <= arb;
      end
      if (transfer) ptr <= gnt_rot;
    end
  end

  oht2bin_base #(
    .WIDTH         (WIDTH),
    .IMPLEMENTATION(0),
    .DIRECTION     (DIRECTION)
  ) u_oht2bin (
    .oht(gnt_oht),
    .bin(gnt_bin)
  );

endmodule
